reg_file_sweep: RTL and testbench
=================================

Name: reg_file_sweep

Overview:
- Parametrised successor to the datapath's two-read, one-write register file.
- Adds a synchronous reset that clears every entry with a sequential sweep, a ready flag, optional write-to-read bypass, and an optional hardwired zero register.
- Sits between instruction decode (rs/rt/rd fields) and the ALU/writeback path.
- Read data is registered with 1-cycle latency.

Parameters:
- DATA_WIDTH, 32, width of each entry and of the data ports.
- ADDR_WIDTH, 6, width of each address port; DEPTH = 2**ADDR_WIDTH entries (derived, not overridable).
- ZERO_REG, 1, when 1 entry 0 always reads 0 and writes to it are discarded.
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to the read output (write-first); when 0 the read returns the pre-write value (read-first).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- rs  input  ADDR_WIDTH  read address A.
- rt  input  ADDR_WIDTH  read address B.
- rd  input  ADDR_WIDTH  write address.
- dataIn  input  DATA_WIDTH  write data.
- write_signal  input  1  write enable.
- rsOut  output  DATA_WIDTH  registered read data A.
- rtOut  output  DATA_WIDTH  registered read data B.
- ready  output  1  high when the file is in RUN and accepting accesses.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Nothing is sampled except on the rising edge of clk.
- States: CLEAR, RUN. Counter clr_ptr is ADDR_WIDTH+1 bits wide.
- Reset: any edge with rst=1 sets state=CLEAR, clr_ptr=0, rsOut=0, rtOut=0, ready=0. rst has priority over all other inputs.
- Holding rst high keeps clr_ptr at 0; no entries are cleared while rst=1.
- CLEAR (rst=0), on each edge:
  - entry[clr_ptr] <= 0, then clr_ptr increments.
  - On the edge that clears entry DEPTH-1: state <= RUN, ready <= 1.
  - ready therefore rises on the DEPTH-th edge after the last rst-high edge.
- During CLEAR: write_signal, rd and dataIn are ignored; rsOut and rtOut hold 0.
- RUN, on each edge:
  - rsOut <= rdata(rs) and rtOut <= rdata(rt); both ports are independent and may carry the same address.
  - If write_signal=1: entry[rd] <= dataIn, unless ZERO_REG=1 and rd=0 (write dropped).
- rdata(a) rules, in priority order:
  - ZERO_REG=1 and a=0: return 0.
  - BYPASS=1, write_signal=1 and rd=a (write not dropped): return dataIn.
  - Otherwise: return entry[a] before this edge's write.
- Read latency: address presented before edge N, data visible after edge N. A write at edge N is visible to any read sampled at edge N+1 regardless of BYPASS.
- rst asserted mid-RUN or mid-CLEAR:
  - Any write sampled at the same edge is discarded.
  - The sweep restarts from entry 0 once rst falls.
  - Entries are not guaranteed zero until ready=1.
- Widths are exact; no arithmetic on data. rd, rs and rt always index in range because DEPTH = 2**ADDR_WIDTH.
- No X may propagate to any output after the first rst edge.

Test Plan:
1. Default params: rst high for 3 edges, then low → ready=0 for 63 edges, ready=1 after the 64th edge. Reading every rs/rt 0..63 returns 0.
2. After ready: write rd=5, dataIn=0xDEADBEEF; next cycle rs=5, rt=5 → both outputs 0xDEADBEEF one edge later. Neighbouring entries 4 and 6 read 0.
3. Bypass: same edge write rd=7, dataIn=0x12345678 with rs=7, rt=8 → rsOut=0x12345678, rtOut=0. Repeat with BYPASS=0 and entry 7 previously 0xAAAA0000 → rsOut=0xAAAA0000, then 0x12345678 on the next read.
4. Zero register: write rd=0, dataIn=0xFFFFFFFF with rs=0 → rsOut=0 that cycle and on all later reads. With ZERO_REG=0 the same sequence reads back 0xFFFFFFFF (bypassed same cycle).
5. Reset mid-operation:
   - Fill entries 1..10 with their index.
   - Assert rst for one edge with write_signal=1, rd=3, dataIn=0x99 → rsOut=rtOut=0, ready=0.
   - ready returns 64 edges after rst falls; entries 1..10 and 3 all read 0.
   - write_signal during CLEAR has no effect.
6. Instance ADDR_WIDTH=3, DATA_WIDTH=16, BYPASS=0 → ready after 8 edges. Write 0xBEEF to entry 7, wrap-check entry 0 unaffected; back-to-back writes to rd=7 of 0x0001 then 0x0002 → read returns 0x0002.

Source files
------------

// File: rtl/reg_file_sweep_if.sv
// reg_file_sweep_if: register file access bus (rs/rt read addresses, rd/dataIn/write_signal write, rsOut/rtOut/ready results)
interface reg_file_sweep_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6
);
  logic [ADDR_WIDTH-1:0] rs;
  logic [ADDR_WIDTH-1:0] rt;
  logic [ADDR_WIDTH-1:0] rd;
  logic [DATA_WIDTH-1:0] dataIn;
  logic                  write_signal;
  logic [DATA_WIDTH-1:0] rsOut;
  logic [DATA_WIDTH-1:0] rtOut;
  logic                  ready;
  modport master (output rs, rt, rd, dataIn, write_signal, input rsOut, rtOut, ready);
  modport slave (input rs, rt, rd, dataIn, write_signal, output rsOut, rtOut, ready);
endinterface

// File: rtl/reg_file_sweep.sv
// reg_file_sweep: 2R1W register file with sweep-clear on reset, ready flag, optional bypass and zero register (clk, rst, bus: rs/rt/rd/dataIn/write_signal in, rsOut/rtOut/ready out)
module reg_file_sweep #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 6,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS = 1'b1
) (
  input logic clk,
  input logic rst,
  reg_file_sweep_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, next_state;
  logic [ADDR_WIDTH:0] clr_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic wr_ok;
  logic [DATA_WIDTH-1:0] rs_data, rt_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state <= next_state;
      clr_ptr <= (state == CLEAR) ? clr_ptr + 1'b1 : clr_ptr;
    end
  end
  always_comb begin
    next_state = (state == CLEAR && clr_ptr == (ADDR_WIDTH+1)'(DEPTH-1)) ? RUN : state;
  end
  always_comb begin
    bus.ready = (state == RUN);
  end
  always_comb begin
    wr_ok = bus.write_signal && !(ZERO_REG && bus.rd == '0);
    rs_data = (ZERO_REG && bus.rs == '0) ? '0 :
              (BYPASS && wr_ok && bus.rd == bus.rs) ? bus.dataIn : mem[bus.rs];
    rt_data = (ZERO_REG && bus.rt == '0) ? '0 :
              (BYPASS && wr_ok && bus.rd == bus.rt) ? bus.dataIn : mem[bus.rt];
  end
  always_ff @(posedge clk) begin
    if (!rst && state == CLEAR)
      mem[clr_ptr[ADDR_WIDTH-1:0]] <= '0;
    else if (!rst && wr_ok)
      mem[bus.rd] <= bus.dataIn;
  end
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR) begin
      bus.rsOut <= '0;
      bus.rtOut <= '0;
    end else begin
      bus.rsOut <= rs_data;
      bus.rtOut <= rt_data;
    end
  end
endmodule

// File: tb/tb_reg_file_sweep.sv
// tb_reg_file_sweep: random and directed checks of two reg_file_sweep instances against a behavioural model
module tb_reg_file_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] rs = '0, rt = '0, rd = '0;
  logic [31:0] din = '0;
  logic we = 1'b0;
  int total = 0, bad = 0;
  int ca = 0, cb = 0;
  logic [31:0] ma [64];
  logic [15:0] mb [8];
  logic [31:0] ea_rs = '0, ea_rt = '0;
  logic [15:0] eb_rs = '0, eb_rt = '0;
  bit ra = 0, rb = 0;
  always #5 clk = ~clk;
  reg_file_sweep_if #(.DATA_WIDTH(32), .ADDR_WIDTH(6)) ifa ();
  reg_file_sweep_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) ifb ();
  assign ifa.rs = rs;
  assign ifa.rt = rt;
  assign ifa.rd = rd;
  assign ifa.dataIn = din;
  assign ifa.write_signal = we;
  assign ifb.rs = rs[2:0];
  assign ifb.rt = rt[2:0];
  assign ifb.rd = rd[2:0];
  assign ifb.dataIn = din[15:0];
  assign ifb.write_signal = we;
  reg_file_sweep #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .ZERO_REG(1'b1), .BYPASS(1'b1)) ua (.clk(clk), .rst(rst), .bus(ifa));
  reg_file_sweep #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) ub (.clk(clk), .rst(rst), .bus(ifb));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] rd_a(input logic [5:0] a);
    if (a == 0) return 32'h0;
    if (we && rd == a) return din;
    return ma[a];
  endfunction
  task automatic model_edge();
    if (rst) begin
      ca = 64;
      cb = 8;
      ea_rs = '0; ea_rt = '0; eb_rs = '0; eb_rt = '0;
      ra = 0; rb = 0;
      foreach (ma[i]) ma[i] = '0;
      foreach (mb[i]) mb[i] = '0;
    end else begin
      if (ca > 0) begin
        ca--;
        ea_rs = '0; ea_rt = '0;
        ra = (ca == 0);
      end else begin
        ra = 1;
        ea_rs = rd_a(rs);
        ea_rt = rd_a(rt);
        if (we && rd != 0) ma[rd] = din;
      end
      if (cb > 0) begin
        cb--;
        eb_rs = '0; eb_rt = '0;
        rb = (cb == 0);
      end else begin
        rb = 1;
        eb_rs = mb[rs[2:0]];
        eb_rt = mb[rt[2:0]];
        if (we) mb[rd[2:0]] = din[15:0];
      end
    end
  endtask
  task automatic step(input logic r, input logic w, input logic [5:0] s, input logic [5:0] t,
                      input logic [5:0] d, input logic [31:0] v);
    rst = r; we = w; rs = s; rt = t; rd = d; din = v;
    @(posedge clk);
    model_edge();
    #1;
    chk("a_ready", 32'(ifa.ready), 32'(ra));
    chk("a_rsOut", ifa.rsOut, ea_rs);
    chk("a_rtOut", ifa.rtOut, ea_rt);
    chk("b_ready", 32'(ifb.ready), 32'(rb));
    chk("b_rsOut", 32'(ifb.rsOut), 32'(eb_rs));
    chk("b_rtOut", 32'(ifb.rtOut), 32'(eb_rt));
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 6'd0, 6'd0, 6'd0, 32'h0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) step(1, 1, 6'd1, 6'd2, 6'd3, 32'h55);
    for (int i = 0; i < 64; i++) step(0, 1, 6'($urandom), 6'($urandom), 6'($urandom), $urandom);
    chk("a_ready_after_64", 32'(ifa.ready), 32'd1);
    for (int i = 0; i < 64; i++) step(0, 0, 6'(i), 6'(63 - i), 6'd0, 32'h0);
    step(0, 1, 6'd0, 6'd0, 6'd5, 32'hDEADBEEF);
    step(0, 0, 6'd5, 6'd5, 6'd0, 32'h0);
    chk("a_read5", ifa.rsOut, 32'hDEADBEEF);
    step(0, 0, 6'd4, 6'd6, 6'd0, 32'h0);
    chk("a_read4", ifa.rsOut, 32'h0);
    step(0, 1, 6'd0, 6'd0, 6'd7, 32'hAAAA0000);
    step(0, 1, 6'd7, 6'd8, 6'd7, 32'h12345678);
    chk("a_bypass", ifa.rsOut, 32'h12345678);
    chk("b_readfirst", 32'(ifb.rsOut), 32'h0000);
    step(0, 0, 6'd7, 6'd8, 6'd0, 32'h0);
    chk("b_after_write", 32'(ifb.rsOut), 32'h5678);
    step(0, 1, 6'd0, 6'd0, 6'd0, 32'hFFFFFFFF);
    chk("a_zero_same", ifa.rsOut, 32'h0);
    step(0, 0, 6'd0, 6'd0, 6'd0, 32'h0);
    chk("a_zero_later", ifa.rsOut, 32'h0);
    chk("b_no_zero_reg", 32'(ifb.rsOut), 32'hFFFF);
    step(0, 1, 6'd0, 6'd0, 6'd7, 32'h0001);
    step(0, 1, 6'd0, 6'd0, 6'd7, 32'h0002);
    step(0, 0, 6'd7, 6'd0, 6'd0, 32'h0);
    chk("b_b2b", 32'(ifb.rsOut), 32'h0002);
    for (int i = 1; i <= 10; i++) step(0, 1, 6'd0, 6'd0, 6'(i), 32'(i));
    step(1, 1, 6'd3, 6'd3, 6'd3, 32'h99);
    chk("a_rst_ready", 32'(ifa.ready), 32'd0);
    for (int i = 0; i < 64; i++) step(0, 1, 6'd3, 6'd3, 6'(i), 32'hCAFE0000 | 32'(i));
    for (int i = 1; i <= 10; i++) step(0, 0, 6'(i), 6'd3, 6'd0, 32'h0);
    for (int i = 0; i < 1500; i++) begin
      logic [5:0] a = 6'($urandom), b = 6'($urandom_range(0, 15));
      step(($urandom_range(0, 199) == 0), $urandom_range(0, 1) == 1, a, b,
           ($urandom_range(0, 3) == 0) ? a : 6'($urandom_range(0, 15)), $urandom);
    end
    idle(70);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
